my_fft_sram: RTL and testbench

Synchronous single-clock FIFO built on a small internal SRAM array. It buffers 8-bit data words between a producer and a consumer, presents the oldest word on `data_out` in show-ahead (first-word-fall-through) form, flags non-empty with `ready`, and latches an `overflow` error when a write is lost. It serves as the elastic buffer in front of the FFT datapath.

---
 rtl/my_fft_sram_pkg.sv | 9 +
 rtl/my_fft_sram_mem.sv | 23 ++
 rtl/my_fft_sram.sv | 75 +++++++
 tb/tb_my_fft_sram.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/my_fft_sram_pkg.sv
// Shared defaults and sizing helper for the my_fft_sram elastic buffer.
package my_fft_sram_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/my_fft_sram_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module my_fft_sram_mem
  import my_fft_sram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/my_fft_sram.sv
// Show-ahead synchronous FIFO with sticky overflow flag, used as the elastic
// buffer in front of the FFT datapath.
module my_fft_sram
  import my_fft_sram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             read,
  input  logic             write,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ready,
  output logic             overflow
);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [PW:0]      r_count;
  logic             r_overflow;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = read & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push  = write & (~w_full | w_pop);
  assign w_drop  = write & ~w_push;

  my_fft_sram_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~clrn),
    .i_waddr (r_wp),
    .i_wdata (data_in),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (clrn) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign ready    = ~w_empty;
  assign data_out = w_empty ? '0 : w_rdata;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_my_fft_sram.sv
// Directed bench for my_fft_sram: stimulus pushes expected words into a
// queue, a separate monitor pops and compares whenever the head is consumed.
module tb_my_fft_sram;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             clrn;
  logic             read;
  logic             write;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_ovf = 1'b0;
  logic             mon_en  = 1'b0;

  my_fft_sram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, update the expected model for
  // the coming rising edge, and return just after that edge.
  task automatic cyc(input logic c, input logic r, input logic w, input logic [WIDTH-1:0] d);
    @(negedge clk);
    clrn = c; read = r; write = w; data_in = d;
    #3;
    if (c) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else if (w) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the visible state every cycle and consumes the head
  // word whenever a pop is presented.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("ready", ready, exp_q.size() != 0);
        chk("overflow", overflow, exp_ovf);
        chk("count", dut.r_count, exp_q.size());
        if (exp_q.size() != 0) begin
          chk("data_out", data_out, exp_q[0]);
          if (read && !clrn) void'(exp_q.pop_front());
        end else begin
          chk("data_out_empty", data_out, 0);
        end
      end
    end
  end

  initial begin
    clrn = 1'b1; read = 1'b0; write = 1'b0; data_in = '0;

    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    mon_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_ready", ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data_out", data_out, 0);

    // Fill in order
    cyc(1'b0, 1'b0, 1'b1, 8'hE0);
    chk("first_ready", ready, 1);
    chk("first_head", data_out, 8'hE0);
    for (int i = 1; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'hE0 + i));
    chk("fill_head", data_out, 8'hE0);
    chk("fill_count", dut.r_count, 5);

    // Concurrent streaming
    cyc(1'b0, 1'b1, 1'b1, 8'hE5);
    chk("stream_head1", data_out, 8'hE1);
    cyc(1'b0, 1'b1, 1'b1, 8'hE6);
    chk("stream_head2", data_out, 8'hE2);
    cyc(1'b0, 1'b1, 1'b1, 8'hE7);
    chk("stream_head3", data_out, 8'hE3);
    chk("stream_count", dut.r_count, 5);

    // Fill to full, then overflow
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'hE8 + i));
    chk("full_count", dut.r_count, 8);
    chk("full_ovf_clear", overflow, 0);
    cyc(1'b0, 1'b0, 1'b1, 8'hEB);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", data_out, 8'hE3);
    chk("ovf_count", dut.r_count, 8);

    // Full with simultaneous read and write
    cyc(1'b0, 1'b1, 1'b1, 8'hF0);
    chk("fullrw_head", data_out, 8'hE4);
    chk("fullrw_count", dut.r_count, 8);
    chk("fullrw_ovf", overflow, 1);

    // Drain across the pointer wrap
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_ready", ready, 0);
    chk("drain_data_out", data_out, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // Read while empty is ignored
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("empty_read_count", dut.r_count, 0);
    chk("empty_read_ready", ready, 0);

    // Read and write while empty: only the push lands
    cyc(1'b0, 1'b1, 1'b1, 8'h5A);
    chk("empty_rw_head", data_out, 8'h5A);
    chk("empty_rw_ready", ready, 1);

    // Reset mid-stream, with requests asserted
    cyc(1'b0, 1'b0, 1'b1, 8'h3C);
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    chk("midrst_ready", ready, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_data_out", data_out, 0);
    cyc(1'b0, 1'b0, 1'b1, 8'h99);
    chk("post_rst_head", data_out, 8'h99);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
